// File: rtl/flight_frame_sched.sv
// rtl/flight_frame_sched.sv - flight-record frame scheduler and shared read-port arbiter
module flight_frame_sched #(
  parameter int FRAME_PERIOD = 50000,
  parameter int FRAME_HIGH   = 256,
  parameter int RD_LAT       = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        frame,
  output logic [3:0]  frame_cnt,
  output logic        buf_valid,
  output logic [7:0]  overrun_cnt,
  input  logic        a_req,
  input  logic        b_req,
  input  logic [6:0]  a_addr,
  input  logic [6:0]  b_addr,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_valid,
  output logic        b_valid,
  output logic [6:0]  rd_FLIGHT,
  input  logic [31:0] FLIGHT_out
);

  localparam logic [23:0] HIGH_LAST   = 24'(FRAME_HIGH - 1);
  localparam logic [23:0] PERIOD_LAST = 24'(FRAME_PERIOD - 1);
  // Grants starting in the last two period cycles would collide with the frame start.
  localparam logic [23:0] GRANT_LIMIT = 24'(FRAME_PERIOD - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2,
    DEFER = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [23:0]       cnt;
  logic              a_own;
  logic              b_own;
  logic              last_b;
  logic [RD_LAT-1:0] a_pipe;
  logic [RD_LAT-1:0] b_pipe;
  logic              gnt_active;
  logic              rise;
  logic              fall;
  logic              defer;
  logic              can_grant;
  logic              pick_a;
  logic              pick_b;
  logic              unused_flight_data;

  // A grant is only live while its requester keeps asking, so a dropped
  // request releases the read port in the same cycle.
  assign a_gnt      = a_own & a_req;
  assign b_gnt      = b_own & b_req;
  assign gnt_active = a_gnt | b_gnt;

  assign frame     = (state == FRAME);
  assign rd_FLIGHT = a_gnt ? a_addr : (b_gnt ? b_addr : 7'd0);
  assign a_valid   = a_pipe[RD_LAT-1];
  assign b_valid   = b_pipe[RD_LAT-1];

  assign rise  = (state_next == FRAME) && (state != FRAME);
  assign fall  = (state == FRAME) && (state_next == GAP);
  assign defer = (state == GAP) && (state_next == DEFER);

  // The owner register stays set for the cycle its request drops, which
  // enforces an idle cycle between bursts.
  assign can_grant = buf_valid && (state == GAP) && (cnt < GRANT_LIMIT) && !a_own && !b_own;
  assign pick_a    = a_req && (!b_req || last_b);
  assign pick_b    = b_req && (!a_req || !last_b);

  // Read data goes straight from the RAM to the requesters; only the timing lives here.
  assign unused_flight_data = ^FLIGHT_out;

  // Next-state decode of the frame scheduler.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (enable) state_next = FRAME;
      FRAME: if (cnt == HIGH_LAST) state_next = GAP;
      GAP: begin
        if (cnt == PERIOD_LAST) begin
          if (!enable)          state_next = IDLE;
          else if (!gnt_active) state_next = FRAME;
          else                  state_next = DEFER;
        end
      end
      DEFER: if (!gnt_active) state_next = FRAME;
      default: state_next = IDLE;
    endcase
  end

  // State register, period counter, frame index, record-valid flag and overrun count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_cnt   <= '0;
      buf_valid   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state <= state_next;
      if (rise || state == IDLE) cnt <= '0;
      else                       cnt <= cnt + 24'd1;
      if (fall) frame_cnt <= frame_cnt + 4'd1;
      if (fall)      buf_valid <= 1'b1;
      else if (rise) buf_valid <= 1'b0;
      if (defer && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  // Round-robin ownership of the read port; last_b remembers who was served last.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_own  <= 1'b0;
      b_own  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      a_own <= a_own ? a_req : (can_grant && pick_a);
      b_own <= b_own ? b_req : (can_grant && pick_b);
      if (can_grant && pick_a)      last_b <= 1'b0;
      else if (can_grant && pick_b) last_b <= 1'b1;
    end
  end

  // Read-latency shift registers; entries already in flight drain regardless of grant or state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else begin
      a_pipe <= RD_LAT'({a_pipe, a_gnt});
      b_pipe <= RD_LAT'({b_pipe, b_gnt});
    end
  end

endmodule
